// File: rtl/pwm_duty_sequencer_pkg.sv
// rtl/pwm_duty_sequencer_pkg.sv - sequencer state encoding, defaults and duty step helper (PWM_SEQ_RAMP_EN selects ramped steps)
package pwm_seq_pkg;

    localparam int DEFAULT_PERIOD_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t ARMED    = 2'd1;
    localparam state_t PLAY     = 2'd2;
    localparam state_t STOPPING = 2'd3;

    // Duty value to present after a boundary when heading towards tgt
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef PWM_SEQ_RAMP_EN
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end else begin
            return cur;
        end
`else
        return (cur == tgt) ? cur : tgt;
`endif
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// rtl/pwm_duty_sequencer_if.sv - host/PWM-side signal bundle for the duty sequencer
interface pwm_duty_sequencer_if #(
    parameter int AW     = 4,
    parameter int HOLD_W = 8
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;
    logic [AW-1:0]     seq_last;
    logic [HOLD_W-1:0] hold_periods;
    logic              loop;
    logic              start;
    logic              stop;
    logic [7:0]        Dato;
    logic              period_start;
    logic              busy;
    logic              done;
    logic [AW-1:0]     idx;

    modport master (
        output wr_en, wr_addr, wr_data, seq_last, hold_periods, loop, start, stop,
        input  Dato, period_start, busy, done, idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, seq_last, hold_periods, loop, start, stop,
        output Dato, period_start, busy, done, idx
    );
endinterface

// File: rtl/pwm_duty_sequencer_period_counter.sv
// rtl/pwm_duty_sequencer_period_counter.sv - free-running PWM period counter with boundary flag
module pwm_period_counter
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_boundary
);

    logic [PERIOD_W-1:0] r_cnt;

    // Count 0..2**PERIOD_W-1 and wrap, mirroring the PWM block's own counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    // A period boundary is the cycle the count sits at zero
    always_comb begin
        o_boundary = (r_cnt == '0);
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - plays a duty table into the PWM Dato input, one entry per N periods (PWM_SEQ_RAMP_EN: ramped steps)
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int PERIOD_W = DEFAULT_PERIOD_W,
    parameter int HOLD_W   = 8
) (
    input  logic                 clk_in,
    input  logic                 reset,
    pwm_duty_sequencer_if.slave  bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_table [DEPTH];
    logic [7:0]        r_dato;
    logic [7:0]        r_target;
    logic [AW-1:0]     r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic              r_done;
    logic              r_fin;

    logic              w_boundary;
    logic              w_last;
    logic              w_settled;
    logic              w_advance;
    logic              w_finish;
    logic [AW-1:0]     w_adv_idx;
    logic [7:0]        w_adv_val;
    logic [7:0]        w_adv_step;
    logic [7:0]        w_tbl0;
    logic [7:0]        w_ramp_step;
    logic [7:0]        w_zero_step;

    pwm_period_counter #(.PERIOD_W(PERIOD_W)) u_period (
        .i_clk      (clk_in),
        .i_reset    (reset),
        .o_boundary (w_boundary)
    );

    // Single write port; table contents deliberately survive reset
    always_ff @(posedge clk_in) begin
        if (bus.wr_en) begin
            r_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Advance decisions and async table reads; idx beyond a lowered seq_last counts as last
    always_comb begin
        w_last      = (r_idx >= bus.seq_last);
        w_adv_idx   = w_last ? '0 : r_idx + AW'(1);
        w_adv_val   = r_table[w_adv_idx];
        w_adv_step  = step_toward(r_dato, w_adv_val);
        w_tbl0      = r_table[0];
        w_ramp_step = step_toward(r_dato, r_target);
        w_zero_step = step_toward(r_dato, 8'h00);
        w_settled   = (r_dato == r_target);
        w_advance   = w_boundary && w_settled && (r_hold == '0);
        w_finish    = w_advance && w_last && !bus.loop;
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: stop beats start and beats a same-cycle boundary
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                if (bus.stop) begin
                    w_next_state = STOPPING;
                end else if (w_boundary) begin
                    w_next_state = PLAY;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    w_next_state = STOPPING;
                end else if (w_finish) begin
                    w_next_state = (w_zero_step == 8'h00) ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                if (w_boundary && (w_zero_step == 8'h00)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: Dato, idx and hold count only move on period boundaries
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_dato   <= 8'h00;
            r_target <= 8'h00;
            r_idx    <= '0;
            r_hold   <= '0;
            r_done   <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_idx <= '0;
                        r_fin <= 1'b0;
                    end
                end
                ARMED: begin
                    if (!bus.stop && w_boundary) begin
                        r_target <= w_tbl0;
                        r_dato   <= step_toward(r_dato, w_tbl0);
                        r_hold   <= bus.hold_periods;
                    end
                end
                PLAY: begin
                    if (!bus.stop && w_boundary) begin
                        if (!w_settled) begin
                            // Still ramping: the hold count restarts until the target is reached
                            r_dato <= w_ramp_step;
                            r_hold <= bus.hold_periods;
                        end else if (r_hold != '0) begin
                            r_hold <= r_hold - HOLD_W'(1);
                        end else if (!w_last || bus.loop) begin
                            r_idx    <= w_adv_idx;
                            r_target <= w_adv_val;
                            r_dato   <= w_adv_step;
                            r_hold   <= bus.hold_periods;
                        end else begin
                            r_target <= 8'h00;
                            r_dato   <= w_zero_step;
                            if (w_zero_step == 8'h00) begin
                                r_done <= 1'b1;
                            end else begin
                                r_fin <= 1'b1;
                            end
                        end
                    end
                end
                STOPPING: begin
                    if (bus.stop) begin
                        r_fin <= 1'b0;
                    end
                    if (w_boundary) begin
                        r_target <= 8'h00;
                        r_dato   <= w_zero_step;
                        if (w_zero_step == 8'h00) begin
                            // A finish that had to ramp down reports done on reaching zero
                            r_done <= r_fin && !bus.stop;
                            r_fin  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_dato <= 8'h00;
                end
            endcase
        end
    end

    // Outputs: busy covers every non-idle state
    always_comb begin
        bus.Dato         = r_dato;
        bus.idx          = r_idx;
        bus.busy         = (r_state != IDLE);
        bus.done         = r_done;
        bus.period_start = w_boundary;
    end

endmodule
